// File: rtl/lfsr_pkg.sv
// Shared types, constants and the single-step LFSR helper for the scrambler slice.
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_W = 32;

    localparam logic [7:0]  TAPS_8  = 8'h5A;
    localparam logic [15:0] TAPS_16 = 16'hB400;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } lfsr_fsm_e;

    // One Fibonacci step on a zero-extended state: returns {next_state, feedback_bit}.
    function automatic logic [LFSR_MAX_W:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps
    );
        logic fb;
        fb = ^(state & taps);
        return {state[LFSR_MAX_W-2:0], fb, fb};
    endfunction

endpackage

// File: rtl/lfsr_scrambler_param_if.sv
// Valid/ready beat bus for the scrambler: input stream and output stream.
interface lfsr_scrambler_param_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lfsr_keystream_gen.sv
// Unrolled DATA_W-step LFSR: per-beat keystream bits and the post-beat state.
module lfsr_keystream_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned LFSR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic [LFSR_W-1:0] state,
    input  logic [LFSR_W-1:0] taps,
    output logic [DATA_W-1:0] keystream,
    output logic [LFSR_W-1:0] state_next
);

    localparam logic [LFSR_MAX_W-1:0] STATE_MASK = LFSR_MAX_W'((64'd1 << LFSR_W) - 64'd1);

    logic [LFSR_MAX_W-1:0] st;
    logic [LFSR_MAX_W:0]   step;

    // Walk the LFSR DATA_W times; keystream bit j is the feedback of step j.
    always_comb begin
        st        = LFSR_MAX_W'(state);
        step      = '0;
        keystream = '0;
        for (int unsigned j = 0; j < DATA_W; j++) begin
            step         = lfsr_step(st, LFSR_MAX_W'(taps));
            keystream[j] = step[0];
            st           = step[LFSR_MAX_W:1] & STATE_MASK;
        end
        state_next = st[LFSR_W-1:0];
    end

endmodule

// File: rtl/lfsr_scrambler_param.sv
// Additive LFSR scrambler/descrambler with valid/ready flow control, runtime
// seed load and bypass. Define LFSR_ZERO_GUARD_EN to enable all-zero lock-up
// recovery (ST_RECOVER state and sticky lockup_err).
module lfsr_scrambler_param
    import lfsr_pkg::*;
#(
    parameter int unsigned       LFSR_W = 8,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(TAPS_8),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(1),
    parameter int unsigned       DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  seed_load,
    input  logic [LFSR_W-1:0]     seed_val,
    lfsr_scrambler_param_if.slave bus,
    output logic [LFSR_W-1:0]     lfsr_state,
    output logic                  lockup_err
);

    lfsr_fsm_e         fsm;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] ks_state;
    logic [DATA_W-1:0] ks;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              in_ready_c;
    logic              accept_c;
    logic              zero_hit_c;

    lfsr_keystream_gen #(
        .LFSR_W (LFSR_W),
        .DATA_W (DATA_W)
    ) u_keystream (
        .state      (lfsr_q),
        .taps       (TAPS),
        .keystream  (ks),
        .state_next (ks_state)
    );

    assign in_ready_c = (!out_valid_q || bus.out_ready) && !seed_load && (fsm == ST_RUN);
    assign accept_c   = bus.in_valid && in_ready_c;

    // Next LFSR value: recovery beats seed load beats an enabled beat.
    always_comb begin
        lfsr_d = lfsr_q;
        if (fsm == ST_RECOVER) begin
            lfsr_d = SEED;
        end else if (seed_load) begin
            lfsr_d = seed_val;
        end else if (accept_c && en) begin
            lfsr_d = ks_state;
        end
    end

`ifdef LFSR_ZERO_GUARD_EN
    logic lockup_err_q;

    assign zero_hit_c = (fsm == ST_RUN) && (lfsr_d == '0);
    assign lockup_err = lockup_err_q;

    // Sticky lock-up flag, set on the recovery cycle, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lockup_err_q <= 1'b0;
        end else if (fsm == ST_RECOVER) begin
            lockup_err_q <= 1'b1;
        end
    end
`else
    assign zero_hit_c = 1'b0;
    assign lockup_err = 1'b0;
`endif

    // FSM, LFSR and output-beat registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= ST_RUN;
            lfsr_q      <= SEED;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            if (accept_c) begin
                out_valid_q <= 1'b1;
                out_data_q  <= en ? (bus.in_data ^ ks) : bus.in_data;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (fsm)
                ST_RUN:     if (zero_hit_c) fsm <= ST_RECOVER;
                ST_RECOVER: fsm <= ST_RUN;
                default:    fsm <= ST_RUN;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign lfsr_state    = lfsr_q;

endmodule
